// File: rtl/dbg_access_ctrl.sv
// Debug access controller: halts the CPU at an instruction boundary and sequences
// host register/memory commands through the datapath debug ports.
//
// state      | meaning
// RUN        | CPU running, watching for halt request or breakpoint
// WAIT_BND   | halt requested, waiting for instruction boundary
// STEP       | single-step: one instruction runs, halt at next boundary
// BRK_IDLE   | halted, ready for host command or resume
// EXEC       | one-cycle command execution (strobes fire here)
// MEM_WAIT   | waiting out data memory read latency
// RESP       | response held until the host takes it
module dbg_access_ctrl #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brk_req,
  input  logic       bp_hit,
  input  logic       cont_req,
  input  logic       step_req,
  input  logic       instr_boundary,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       dbg_is_brk,
  output logic [7:0] dbg_addr_in,
  output logic [7:0] dbg_data_in,
  output logic       dbg_reg_wr,
  output logic       dbg_mem_wr,
  output logic       dbg_mem_rd,
  input  logic [7:0] dbg_reg_dout,
  input  logic [7:0] data_mem_din
);

  typedef enum logic [2:0] {
    S_RUN,
    S_WAIT_BND,
    S_STEP,
    S_BRK_IDLE,
    S_EXEC,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_REG_RD = 2'b00;
  localparam logic [1:0] OP_REG_WR = 2'b01;
  localparam logic [1:0] OP_MEM_RD = 2'b10;
  localparam logic [1:0] OP_MEM_WR = 2'b11;

  // Counter is loaded with latency-1 so that it reaches zero in the cycle the data is valid.
  localparam logic [1:0] CNT_INIT = (MEM_RD_LAT == 0) ? 2'd0 : 2'(MEM_RD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] cnt_q, cnt_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       dbg_is_brk_q, dbg_is_brk_d;
  logic [7:0] dbg_data_in_q, dbg_data_in_d;
  logic       dbg_reg_wr_q, dbg_reg_wr_d;
  logic       dbg_mem_wr_q, dbg_mem_wr_d;
  logic       dbg_mem_rd_q, dbg_mem_rd_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_RUN: begin
        if (instr_boundary && (brk_req || bp_hit)) begin
          state_d = S_BRK_IDLE;
        end else if (brk_req) begin
          state_d = S_WAIT_BND;
        end
      end
      S_WAIT_BND: begin
        if (instr_boundary) state_d = S_BRK_IDLE;
      end
      S_STEP: begin
        if (instr_boundary) state_d = S_BRK_IDLE;
      end
      S_BRK_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = S_EXEC;
        end else if (step_req) begin
          state_d = S_STEP;
        end else if (cont_req) begin
          state_d = S_RUN;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_REG_RD: begin
            rdata_d = dbg_reg_dout;
            state_d = S_RESP;
          end
          OP_MEM_RD: begin
            if (MEM_RD_LAT == 0) begin
              rdata_d = data_mem_din;
              state_d = S_RESP;
            end else begin
              cnt_d   = CNT_INIT;
              state_d = S_MEM_WAIT;
            end
          end
          default: begin
            rdata_d = 8'h00;
            state_d = S_RESP;
          end
        endcase
      end
      S_MEM_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = data_mem_din;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_BRK_IDLE;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs are registered: each is computed from the state being entered.
  always_comb begin
    dbg_is_brk_d  = (state_d == S_BRK_IDLE) || (state_d == S_EXEC) ||
                    (state_d == S_MEM_WAIT) || (state_d == S_RESP);
    cmd_ready_d   = (state_d == S_BRK_IDLE);
    rsp_valid_d   = (state_d == S_RESP);
    rsp_data_d    = (state_d == S_RESP) ? rdata_d : 8'h00;
    dbg_data_in_d = ((state_d == S_EXEC) || (state_d == S_MEM_WAIT) ||
                     (state_d == S_RESP)) ? wdata_d : 8'h00;
    dbg_reg_wr_d  = (state_d == S_EXEC) && (op_d == OP_REG_WR);
    dbg_mem_wr_d  = (state_d == S_EXEC) && (op_d == OP_MEM_WR);
    dbg_mem_rd_d  = (state_d == S_EXEC) && (op_d == OP_MEM_RD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      op_q          <= 2'b00;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      cnt_q         <= 2'd0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      dbg_is_brk_q  <= 1'b0;
      dbg_data_in_q <= 8'h00;
      dbg_reg_wr_q  <= 1'b0;
      dbg_mem_wr_q  <= 1'b0;
      dbg_mem_rd_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      dbg_is_brk_q  <= dbg_is_brk_d;
      dbg_data_in_q <= dbg_data_in_d;
      dbg_reg_wr_q  <= dbg_reg_wr_d;
      dbg_mem_wr_q  <= dbg_mem_wr_d;
      dbg_mem_rd_q  <= dbg_mem_rd_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign dbg_is_brk  = dbg_is_brk_q;
  assign dbg_addr_in = addr_q;
  assign dbg_data_in = dbg_data_in_q;
  assign dbg_reg_wr  = dbg_reg_wr_q;
  assign dbg_mem_wr  = dbg_mem_wr_q;
  assign dbg_mem_rd  = dbg_mem_rd_q;

endmodule

// File: tb/tb_dbg_access_ctrl.sv
// Bench for dbg_access_ctrl: behavioural register file / memory around the DUT,
// with a scoreboard of expected contents and directed plus random command sequences.
module tb_dbg_access_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       brk_req, bp_hit, cont_req, step_req, instr_boundary;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       dbg_is_brk;
  logic [7:0] dbg_addr_in, dbg_data_in;
  logic       dbg_reg_wr, dbg_mem_wr, dbg_mem_rd;
  logic [7:0] dbg_reg_dout, data_mem_din;

  int n_checks = 0;
  int n_err    = 0;
  int n_reg_wr = 0, n_mem_wr = 0, n_mem_rd = 0;

  logic [7:0] dp_regs [16];
  logic [7:0] dp_mem  [256];
  logic [7:0] exp_regs[16];
  logic [7:0] exp_mem [256];

  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [7:0] p1_d = 8'h00, p2_d = 8'h00;

  dbg_access_ctrl #(.MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .brk_req(brk_req), .bp_hit(bp_hit),
    .cont_req(cont_req), .step_req(step_req), .instr_boundary(instr_boundary),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .dbg_is_brk(dbg_is_brk),
    .dbg_addr_in(dbg_addr_in), .dbg_data_in(dbg_data_in),
    .dbg_reg_wr(dbg_reg_wr), .dbg_mem_wr(dbg_mem_wr), .dbg_mem_rd(dbg_mem_rd),
    .dbg_reg_dout(dbg_reg_dout), .data_mem_din(data_mem_din)
  );

  always #5 clk = ~clk;

  // Datapath model: register file with async X-port, memory with a LAT-cycle read pipe.
  assign dbg_reg_dout = dp_regs[dbg_addr_in[3:0]];
  assign data_mem_din = p2_v ? p2_d : 8'hEE;

  always @(posedge clk) begin
    if (dbg_reg_wr) dp_regs[dbg_addr_in[3:0]] <= dbg_data_in;
    if (dbg_mem_wr) dp_mem[dbg_addr_in] <= dbg_data_in;
    p1_v <= dbg_mem_rd;
    p1_d <= dp_mem[dbg_addr_in];
    p2_v <= p1_v;
    p2_d <= p1_d;
  end

  always @(negedge clk) begin
    if (dbg_reg_wr) n_reg_wr++;
    if (dbg_mem_wr) n_mem_wr++;
    if (dbg_mem_rd) n_mem_rd++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_noise();
    cont_req       = 1'($urandom_range(0, 1));
    step_req       = 1'($urandom_range(0, 1));
    brk_req        = 1'($urandom_range(0, 1));
    bp_hit         = 1'($urandom_range(0, 1));
    instr_boundary = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_noise();
    cont_req = 0; step_req = 0; brk_req = 0; bp_hit = 0; instr_boundary = 0;
  endtask

  // Issue one command from the halted-idle state and check the whole transaction.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                        input int hold, input bit noise, input bit cont_same);
    int lat, guard, rw0, mw0, mr0;
    logic [7:0] exp_d;
    exp_d = (op == 2'b00) ? exp_regs[addr[3:0]] : (op == 2'b10) ? exp_mem[addr] : 8'h00;
    guard = 0;
    while (!cmd_ready && guard < 5) begin
      tick();
      guard++;
    end
    chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
    if (!cmd_ready) return;
    rw0 = n_reg_wr; mw0 = n_mem_wr; mr0 = n_mem_rd;
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    cont_req = cont_same;
    tick();
    cmd_valid = 0; cont_req = 0;
    cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    chk("exec_addr", {24'd0, dbg_addr_in}, {24'd0, addr});
    chk("exec_data", {24'd0, dbg_data_in}, {24'd0, wd});
    chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
    chk("busy_halted", {31'd0, dbg_is_brk}, 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (noise) drive_noise();
      tick();
      lat++;
    end
    chk("rsp_latency", lat, (op == 2'b10) ? 2 + LAT : 2);
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
    for (int i = 0; i < hold; i++) begin
      if (noise) drive_noise();
      tick();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {24'd0, rsp_data}, {24'd0, exp_d});
      chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    clear_noise();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_halted", {31'd0, dbg_is_brk}, 32'd1);
    chk("idle_data", {24'd0, dbg_data_in}, 32'd0);
    chk("reg_wr_pulses", n_reg_wr - rw0, (op == 2'b01) ? 1 : 0);
    chk("mem_wr_pulses", n_mem_wr - mw0, (op == 2'b11) ? 1 : 0);
    chk("mem_rd_pulses", n_mem_rd - mr0, (op == 2'b10) ? 1 : 0);
    if (op == 2'b01) exp_regs[addr[3:0]] = wd;
    if (op == 2'b11) exp_mem[addr] = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dp_regs[i]  = 8'($urandom);
      exp_regs[i] = dp_regs[i];
    end
    for (int i = 0; i < 256; i++) begin
      dp_mem[i]  = 8'($urandom);
      exp_mem[i] = dp_mem[i];
    end
    rst = 1; clear_noise();
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    tick();
    tick();
    chk("rst_is_brk", {31'd0, dbg_is_brk}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {29'd0, dbg_reg_wr, dbg_mem_wr, dbg_mem_rd}, 32'd0);
    chk("rst_buses", {8'd0, rsp_data, dbg_addr_in, dbg_data_in}, 32'd0);
    rst = 0;

    // Halt request waits for the instruction boundary.
    brk_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_bnd_running", {31'd0, dbg_is_brk}, 32'd0);
    end
    instr_boundary = 1;
    tick();
    instr_boundary = 0; brk_req = 0;
    chk("halt_is_brk", {31'd0, dbg_is_brk}, 32'd1);
    chk("halt_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd(2'b01, 8'h05, 8'hA5, 0, 0, 0);
    do_cmd(2'b00, 8'h05, 8'h00, 0, 0, 0);
    chk("regfile_written", {24'd0, dp_regs[5]}, 32'hA5);
    dp_mem[8'h80] = 8'h3C; exp_mem[8'h80] = 8'h3C;
    do_cmd(2'b10, 8'h80, 8'h00, 5, 0, 0);

    for (int n = 0; n < 40; n++)
      do_cmd(2'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1, 0);

    // Command wins over a simultaneous resume; resume alone then runs.
    do_cmd(2'b11, 8'h42, 8'h99, 1, 0, 1);
    chk("mem_written", {24'd0, dp_mem[8'h42]}, 32'h99);
    cont_req = 1;
    tick();
    cont_req = 0;
    chk("cont_running", {31'd0, dbg_is_brk}, 32'd0);
    chk("cont_not_ready", {31'd0, cmd_ready}, 32'd0);
    instr_boundary = 1;
    tick();
    instr_boundary = 0;
    chk("run_no_halt", {31'd0, dbg_is_brk}, 32'd0);
    bp_hit = 1;
    tick();
    chk("bp_off_boundary", {31'd0, dbg_is_brk}, 32'd0);
    instr_boundary = 1;
    tick();
    instr_boundary = 0; bp_hit = 0;
    chk("bp_halt", {31'd0, dbg_is_brk}, 32'd1);

    // Resume with halt request still high re-halts at the next boundary.
    brk_req = 1; cont_req = 1;
    tick();
    cont_req = 0;
    chk("cont_brk_running", {31'd0, dbg_is_brk}, 32'd0);
    instr_boundary = 1;
    tick();
    instr_boundary = 0; brk_req = 0;
    chk("rehalt", {31'd0, dbg_is_brk}, 32'd1);

    // Single step: one boundary only.
    step_req = 1;
    tick();
    step_req = 0;
    chk("step_running", {31'd0, dbg_is_brk}, 32'd0);
    chk("step_not_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    tick();
    chk("step_wait", {31'd0, dbg_is_brk}, 32'd0);
    instr_boundary = 1;
    tick();
    chk("step_halt", {31'd0, dbg_is_brk}, 32'd1);
    tick();
    instr_boundary = 0;
    chk("step_stays_halted", {31'd0, dbg_is_brk}, 32'd1);
    do_cmd(2'b00, 8'h05, 8'h00, 0, 0, 0);

    // Reset in the middle of a memory read.
    cmd_valid = 1; cmd_op = 2'b10; cmd_addr = 8'h10; cmd_wdata = 8'h77;
    tick();
    cmd_valid = 0;
    tick();
    chk("mem_wait_no_rd", {31'd0, dbg_mem_rd}, 32'd0);
    chk("mem_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_is_brk", {31'd0, dbg_is_brk}, 32'd0);
    chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_strobes", {29'd0, dbg_reg_wr, dbg_mem_wr, dbg_mem_rd}, 32'd0);
    chk("rst_mid_buses", {8'd0, rsp_data, dbg_addr_in, dbg_data_in}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    instr_boundary = 1;
    tick();
    instr_boundary = 0;
    chk("rst_mid_running", {31'd0, dbg_is_brk}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
